// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - core request/response and data memory bus of the load/store unit
interface load_store_unit_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [3:0] req_addr;
  logic [3:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic [3:0] rsp_addr;
  logic       mem_write_en;
  logic [3:0] mem_address;
  logic [3:0] mem_data_in;
  logic [3:0] mem_data_out;
  logic       busy;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_data_out,
    output req_ready, rsp_valid, rsp_data, rsp_addr,
    output mem_write_en, mem_address, mem_data_in, busy
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_data_out,
    input  req_ready, rsp_valid, rsp_data, rsp_addr,
    input  mem_write_en, mem_address, mem_data_in, busy
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - in-order load/store unit with a 2-entry request FIFO
// Serialises core requests onto a registered-read data memory; every output is a flop.
module load_store_unit (
  input  logic              clk,
  input  logic              rst,
  load_store_unit_if.slave  bus
);
  typedef enum logic [2:0] {
    IDLE,
    WR_SETUP,
    WR_PULSE,
    RD_ADDR,
    RD_CAP,
    RSP
  } state_t;

  state_t     state;
  state_t     state_next;

  logic       fifo_we    [2];
  logic [3:0] fifo_addr  [2];
  logic [3:0] fifo_wdata [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic [1:0] count_next;
  logic       push;
  logic       pop;

  logic       mem_write_en_d;
  logic [3:0] mem_address_d;
  logic [3:0] mem_data_in_d;
  logic       rsp_valid_d;
  logic [3:0] rsp_data_d;
  logic [3:0] rsp_addr_d;

  assign push       = bus.req_valid && bus.req_ready;
  assign count_next = count + {1'b0, push} - {1'b0, pop};

  // mem_address doubles as the address of the request being serviced.
  always_comb begin
    state_next     = state;
    pop            = 1'b0;
    mem_write_en_d = 1'b0;
    mem_address_d  = bus.mem_address;
    mem_data_in_d  = bus.mem_data_in;
    rsp_valid_d    = 1'b0;
    rsp_data_d     = bus.rsp_data;
    rsp_addr_d     = bus.rsp_addr;
    case (state)
      IDLE: begin
        if (count != 2'd0) begin
          pop           = 1'b1;
          mem_address_d = fifo_addr[rd_ptr];
          if (fifo_we[rd_ptr]) begin
            mem_data_in_d = fifo_wdata[rd_ptr];
            state_next    = WR_SETUP;
          end else begin
            state_next    = RD_ADDR;
          end
        end
      end
      WR_SETUP: begin
        mem_write_en_d = 1'b1;
        state_next     = WR_PULSE;
      end
      WR_PULSE: state_next = IDLE;
      RD_ADDR:  state_next = RD_CAP;
      RD_CAP: begin
        rsp_data_d = bus.mem_data_out;
        rsp_addr_d = bus.mem_address;
        state_next = RSP;
      end
      RSP: begin
        // rsp_valid is raised from the RSP state itself, so it lags entry by one cycle.
        if (bus.rsp_valid && bus.rsp_ready) begin
          state_next = IDLE;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      count            <= 2'd0;
      wr_ptr           <= 1'b0;
      rd_ptr           <= 1'b0;
      bus.req_ready    <= 1'b0;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_data     <= 4'd0;
      bus.rsp_addr     <= 4'd0;
      bus.mem_write_en <= 1'b0;
      bus.mem_address  <= 4'd0;
      bus.mem_data_in  <= 4'd0;
      bus.busy         <= 1'b0;
    end else begin
      state            <= state_next;
      count            <= count_next;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      bus.req_ready    <= (count_next < 2'd2);
      bus.rsp_valid    <= rsp_valid_d;
      bus.rsp_data     <= rsp_data_d;
      bus.rsp_addr     <= rsp_addr_d;
      bus.mem_write_en <= mem_write_en_d;
      bus.mem_address  <= mem_address_d;
      bus.mem_data_in  <= mem_data_in_d;
      bus.busy         <= (state_next != IDLE) || (count_next != 2'd0);
    end
  end

  // Entry storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_we[wr_ptr]    <= bus.req_we;
      fifo_addr[wr_ptr]  <= bus.req_addr;
      fifo_wdata[wr_ptr] <= bus.req_wdata;
    end
  end
endmodule
